source_ram_ctrl: RTL and testbench

SOURCE_RAM_CTRL -- requirements
Module: source_ram_ctrl

---
 rtl/source_ram_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_source_ram_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/source_ram_ctrl.sv
// Packet buffer controller: streams 12 packets into three 512x128 RAM banks and reads whole packets back out.
// Define SRC_RAM_CTRL_ERRCNT_EN to add a saturating count of rejected read requests on err_cnt.
module source_ram_ctrl #(
    parameter int PKT_WORDS = 128
) (
    input  logic         ram_clk,
    input  logic         rst,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [127:0] wr_data,
    output logic         wr_pkt_done,
    input  logic         rd_req,
    output logic         rd_ack,
    input  logic [3:0]   rd_pkt,
    output logic         rd_valid,
    output logic         rd_last,
    output logic [127:0] rd_data,
    output logic         rd_err,
    output logic [11:0]  pkt_valid,
    output logic         full,
    output logic         empty,
    output logic [383:0] ram_data,
    input  logic [383:0] ram_q,
    output logic [2:0]   ram_wren,
    output logic [2:0]   ram_rden,
    output logic [26:0]  ram_address
`ifdef SRC_RAM_CTRL_ERRCNT_EN
    ,
    output logic [7:0]   err_cnt
`endif
);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RUN  = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RUN  = 1'b1;
    localparam logic [8:0] LAST_WORD = 9'(PKT_WORDS - 1);
    localparam logic [8:0] PKT_SIZE  = 9'(PKT_WORDS);

    logic        alive;
    logic [0:0]  w_state;
    logic [0:0]  r_state;
    logic [3:0]  wp;
    logic [3:0]  rp;
    logic [8:0]  w_cnt;
    logic [8:0]  r_cnt;
    logic [1:0]  rd_bank_q;
    logic [15:0] pv_ext;
    logic [1:0]  w_bank;
    logic [1:0]  r_bank;
    logic [1:0]  rq_bank;
    logic        rd_pkt_ok;
    logic        r_active;
    logic        rd_accept;
    logic        wr_accept;
    logic        w_last;
    logic        r_last;
    logic [8:0]  w_addr;
    logic [8:0]  r_addr;
    logic [11:0] set_mask;
    logic [11:0] clr_mask;

    // Packet p lives in bank p[3:2], slot p[1:0] within that bank.
    assign w_bank  = wp[3:2];
    assign r_bank  = rp[3:2];
    assign rq_bank = rd_pkt[3:2];
    assign pv_ext  = {4'b0000, pkt_valid};
    assign w_addr  = PKT_SIZE * {7'd0, wp[1:0]} + w_cnt;
    assign r_addr  = PKT_SIZE * {7'd0, rp[1:0]} + r_cnt;
    assign w_last  = (w_cnt == LAST_WORD);
    assign r_last  = (r_cnt == LAST_WORD);
    assign r_active = (r_state == R_RUN);

    assign rd_pkt_ok = (rd_pkt < 4'd12) && pv_ext[rd_pkt];
    assign rd_ack    = alive && !r_active && rd_pkt_ok &&
                       !((w_state == W_RUN) && (w_bank == rq_bank));
    assign rd_accept = rd_req && rd_ack;
    assign rd_err    = alive && !r_active && rd_req && !rd_pkt_ok;

    // A read accepted this cycle on the write bank takes priority over a write start.
    assign wr_ready  = alive && !pv_ext[wp] &&
                       !(r_active && (r_bank == w_bank)) &&
                       !(rd_accept && (rq_bank == w_bank));
    assign wr_accept   = wr_valid && wr_ready;
    assign wr_pkt_done = wr_accept && w_last;

    assign full  = &pkt_valid;
    assign empty = ~|pkt_valid;

    always_comb begin
        ram_wren    = '0;
        ram_rden    = '0;
        ram_data    = '0;
        ram_address = '0;
        for (int b = 0; b < 3; b++) begin
            if (wr_accept && (w_bank == 2'(b))) begin
                ram_wren[b]             = 1'b1;
                ram_data[128*b +: 128]  = wr_data;
                ram_address[9*b +: 9]   = w_addr;
            end
            if (r_active && (r_bank == 2'(b))) begin
                ram_rden[b]             = 1'b1;
                ram_address[9*b +: 9]   = r_addr;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int b = 0; b < 3; b++) begin
            if (rd_valid && (rd_bank_q == 2'(b))) begin
                rd_data = ram_q[128*b +: 128];
            end
        end
    end

    // alive holds the handshakes low until the first clock edge after reset releases.
    always_ff @(posedge ram_clk or posedge rst) begin
        if (rst) begin
            alive   <= 1'b0;
            w_state <= W_IDLE;
            wp      <= '0;
            w_cnt   <= '0;
        end else begin
            alive <= 1'b1;
            if (wr_accept) begin
                if (w_last) begin
                    w_state <= W_IDLE;
                    w_cnt   <= '0;
                    wp      <= (wp == 4'd11) ? 4'd0 : wp + 4'd1;
                end else begin
                    w_state <= W_RUN;
                    w_cnt   <= w_cnt + 9'd1;
                end
            end
        end
    end

    always_ff @(posedge ram_clk or posedge rst) begin
        if (rst) begin
            r_state   <= R_IDLE;
            rp        <= '0;
            r_cnt     <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_bank_q <= '0;
        end else begin
            rd_valid  <= r_active;
            rd_last   <= r_active && r_last;
            rd_bank_q <= r_bank;
            if (r_state == R_IDLE) begin
                if (rd_accept) begin
                    r_state <= R_RUN;
                    rp      <= rd_pkt;
                    r_cnt   <= '0;
                end
            end else if (r_last) begin
                r_state <= R_IDLE;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 9'd1;
            end
        end
    end

    // Set and clear never hit the same bit: a write only targets empty packets, a read only full ones.
    assign set_mask = wr_pkt_done ? (12'd1 << wp) : 12'd0;
    assign clr_mask = (r_active && r_last) ? (12'd1 << rp) : 12'd0;

    always_ff @(posedge ram_clk or posedge rst) begin
        if (rst) begin
            pkt_valid <= '0;
        end else begin
            pkt_valid <= (pkt_valid | set_mask) & ~clr_mask;
        end
    end

`ifdef SRC_RAM_CTRL_ERRCNT_EN
    always_ff @(posedge ram_clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (rd_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_source_ram_ctrl.sv
// Self-checking bench for source_ram_ctrl: packet-level model, RAM model, directed scenarios then random traffic.
// Honours SRC_RAM_CTRL_ERRCNT_EN for the optional err_cnt output.
module tb_source_ram_ctrl;

    localparam int PKT_WORDS = 128;

    logic         ram_clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [127:0] wr_data = '0;
    logic         wr_pkt_done;
    logic         rd_req = 1'b0;
    logic         rd_ack;
    logic [3:0]   rd_pkt = '0;
    logic         rd_valid;
    logic         rd_last;
    logic [127:0] rd_data;
    logic         rd_err;
    logic [11:0]  pkt_valid;
    logic         full;
    logic         empty;
    logic [383:0] ram_data;
    logic [383:0] ram_q;
    logic [2:0]   ram_wren;
    logic [2:0]   ram_rden;
    logic [26:0]  ram_address;
`ifdef SRC_RAM_CTRL_ERRCNT_EN
    logic [7:0]   err_cnt;
`endif

    source_ram_ctrl #(.PKT_WORDS(PKT_WORDS)) dut (
        .ram_clk(ram_clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_pkt_done(wr_pkt_done),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_pkt(rd_pkt),
        .rd_valid(rd_valid), .rd_last(rd_last), .rd_data(rd_data), .rd_err(rd_err),
        .pkt_valid(pkt_valid), .full(full), .empty(empty),
        .ram_data(ram_data), .ram_q(ram_q), .ram_wren(ram_wren), .ram_rden(ram_rden),
        .ram_address(ram_address)
`ifdef SRC_RAM_CTRL_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 ram_clk = ~ram_clk;

    // Three 512x128 banks with one cycle of read latency.
    logic [127:0] ram_mem [0:2][0:511];
    logic [383:0] ram_q_r = '0;
    assign ram_q = ram_q_r;

    always @(posedge ram_clk) begin
        for (int b = 0; b < 3; b++) begin
            if (ram_wren[b]) ram_mem[b][ram_address[9*b +: 9]] <= ram_data[128*b +: 128];
            if (ram_rden[b]) ram_q_r[128*b +: 128] <= ram_mem[b][ram_address[9*b +: 9]];
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic checkOutput(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Packet-level reference state
    bit           m_alive;
    bit [11:0]    m_valid;
    int           m_wp, m_wcnt, m_rpkt, m_rleft, m_ridx, m_errcnt;
    bit           p_valid, p_last;
    logic [127:0] p_data;
    logic [127:0] pdata [0:11][0:PKT_WORDS-1];

    int done_cnt = 0, err_pulse_cnt = 0, wr_words = 0, last_cnt = 0;
    int rden1_cnt = 0, rden1_first = 0, rden1_last = 0;
    int wr_mode = 0;

    task automatic model_reset();
        m_alive = 0; m_valid = '0; m_wp = 0; m_wcnt = 0;
        m_rpkt = 0; m_rleft = 0; m_ridx = 0; m_errcnt = 0;
        p_valid = 0; p_last = 0; p_data = '0;
    endtask

    task automatic monitor_step();
        bit rd_busy, pv_rq, ack_e, acc_e, err_e, rdy_e, wacc, done_e;
        int wbank, rp, rbank;
        logic [2:0]   wren_e, rden_e;
        logic [383:0] data_e;
        logic [26:0]  addr_e;
        if (rst) model_reset();
        rd_busy = (m_rleft > 0);
        wbank   = m_wp / 4;
        rp      = int'(rd_pkt);
        rbank   = m_rpkt / 4;
        pv_rq   = (rp < 12) ? m_valid[rp] : 1'b0;
        ack_e   = m_alive && !rd_busy && pv_rq && !(m_wcnt > 0 && rp / 4 == wbank);
        acc_e   = rd_req && ack_e;
        err_e   = m_alive && !rd_busy && rd_req && !pv_rq;
        rdy_e   = m_alive && !m_valid[m_wp] && !(rd_busy && rbank == wbank) &&
                  !(acc_e && rp / 4 == wbank);
        wacc    = wr_valid && rdy_e;
        done_e  = wacc && (m_wcnt == PKT_WORDS - 1);
        wren_e = '0; rden_e = '0; data_e = '0; addr_e = '0;
        if (wacc) begin
            wren_e[wbank] = 1'b1;
            data_e[128*wbank +: 128] = wr_data;
            addr_e[9*wbank +: 9] = 9'((m_wp % 4) * PKT_WORDS + m_wcnt);
        end
        if (rd_busy) begin
            rden_e[rbank] = 1'b1;
            addr_e[9*rbank +: 9] = 9'((m_rpkt % 4) * PKT_WORDS + m_ridx);
        end

        checkOutput("handshake", 384'({wr_ready, rd_ack, rd_err, wr_pkt_done}),
                    384'({rdy_e, ack_e, err_e, done_e}));
        checkOutput("rd_stream", 384'({rd_valid, rd_last, rd_data}),
                    384'({p_valid, p_last, p_valid ? p_data : 128'd0}));
        checkOutput("ram_ctl", 384'({ram_wren, ram_rden, ram_address}), 384'({wren_e, rden_e, addr_e}));
        checkOutput("ram_data", ram_data, data_e);
        checkOutput("status", 384'({pkt_valid, full, empty}), 384'({m_valid, &m_valid, ~|m_valid}));
`ifdef SRC_RAM_CTRL_ERRCNT_EN
        checkOutput("err_cnt", 384'(err_cnt), 384'(m_errcnt));
`endif

        if (wr_pkt_done) done_cnt++;
        if (rd_err) err_pulse_cnt++;
        if (rd_last) last_cnt++;
        if (wr_valid && wr_ready) wr_words++;
        if (ram_rden[1]) begin
            if (rden1_cnt == 0) rden1_first = int'(ram_address[17:9]);
            rden1_last = int'(ram_address[17:9]);
            rden1_cnt++;
        end

        if (!rst) begin
            if (wacc) begin
                pdata[m_wp][m_wcnt] = wr_data;
                if (m_wcnt == PKT_WORDS - 1) begin
                    m_valid[m_wp] = 1'b1;
                    m_wcnt = 0;
                    m_wp = (m_wp + 1) % 12;
                end else begin
                    m_wcnt++;
                end
            end
            p_valid = rd_busy;
            p_last = 0;
            if (rd_busy) begin
                p_data = pdata[m_rpkt][m_ridx];
                p_last = (m_rleft == 1);
                m_ridx++;
                m_rleft--;
                if (m_rleft == 0) m_valid[m_rpkt] = 1'b0;
            end
            if (acc_e) begin
                m_rpkt = rp; m_rleft = PKT_WORDS; m_ridx = 0;
            end
            if (err_e && m_errcnt < 255) m_errcnt++;
            m_alive = 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge ram_clk);
            monitor_step();
        end
    end

    // Write-side driver: fresh random data every cycle, valid per wr_mode.
    initial begin
        forever begin
            @(posedge ram_clk);
            #1;
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            case (wr_mode)
                0: wr_valid = 1'b0;
                1: wr_valid = 1'b1;
                default: wr_valid = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic applyStimulus(input bit req, input logic [3:0] pkt);
        @(posedge ram_clk);
        #1;
        rd_req = req;
        rd_pkt = pkt;
    endtask

    task automatic waitReadDone(input int start_last, input string tag);
        for (int i = 0; i < PKT_WORDS + 20; i++) begin
            @(negedge ram_clk);
            if (last_cnt > start_last) break;
        end
        checkOutput(tag, 384'(last_cnt > start_last), 384'(1));
    endtask

    task automatic readPacket(input int p, input string tag);
        bit ok;
        int sl;
        ok = 0;
        sl = last_cnt;
        applyStimulus(1'b1, 4'(p));
        for (int i = 0; i < 1000; i++) begin
            @(negedge ram_clk);
            if (rd_ack) begin
                ok = 1;
                break;
            end
        end
        checkOutput({tag, "_ack"}, 384'(ok), 384'(1));
        applyStimulus(1'b0, 4'(p));
        waitReadDone(sl, {tag, "_done"});
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int e0, d0, sl;
        bit ok;
        repeat (3) @(posedge ram_clk);
        @(negedge ram_clk);
        checkOutput("reset_state", 384'({pkt_valid, full, empty, wr_ready, rd_ack}),
                    384'({12'h000, 1'b0, 1'b1, 1'b0, 1'b0}));
        @(posedge ram_clk);
        #1 rst = 1'b0;
        @(negedge ram_clk);
        checkOutput("ready_before_edge", 384'(wr_ready), 384'(0));
        @(negedge ram_clk);
        checkOutput("ready_after_edge", 384'(wr_ready), 384'(1));

        // Rejected requests: empty packet, then out-of-range index
        e0 = err_pulse_cnt;
        applyStimulus(1'b1, 4'd2);
        @(negedge ram_clk);
        checkOutput("err_empty", 384'({rd_err, rd_ack}), 384'(2'b10));
        applyStimulus(1'b1, 4'd13);
        @(negedge ram_clk);
        checkOutput("err_index", 384'({rd_err, rd_ack}), 384'(2'b10));
        applyStimulus(1'b0, 4'd0);
        checkOutput("err_pulses", 384'(err_pulse_cnt - e0), 384'(2));
`ifdef SRC_RAM_CTRL_ERRCNT_EN
        checkOutput("err_cnt_lit", 384'(err_cnt), 384'(2));
`endif

        // Reset in the middle of packet 0
        wr_words = 0;
        wr_mode = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge ram_clk);
            if (wr_words >= 60) break;
        end
        @(posedge ram_clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("async_reset_ctl", 384'({wr_ready, rd_ack, rd_valid, rd_last, rd_err, wr_pkt_done,
                    ram_wren, ram_rden, ram_address}), 384'(0));
        checkOutput("async_reset_data", ram_data, 384'(0));
        checkOutput("async_reset_status", 384'({pkt_valid, full, empty}), 384'({12'h000, 1'b0, 1'b1}));
        repeat (2) @(posedge ram_clk);
        #1 rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ram_clk);
            if (ram_wren != 3'b000) break;
        end
        checkOutput("first_write_after_reset", 384'({ram_wren, ram_address[8:0]}), 384'({3'b001, 9'd0}));

        // Fill all twelve packets with continuous valid
        for (int i = 0; i < 12 * PKT_WORDS + 100; i++) begin
            @(negedge ram_clk);
            if (done_cnt >= 12) break;
        end
        repeat (3) @(negedge ram_clk);
        checkOutput("fill_done_pulses", 384'(done_cnt), 384'(12));
        checkOutput("fill_status", 384'({pkt_valid, full, empty, wr_ready}), 384'({12'hFFF, 1'b1, 1'b0, 1'b0}));

        // Read packet 5 out of bank 1
        rden1_cnt = 0;
        readPacket(5, "read_pkt5");
        checkOutput("pkt5_rden_count", 384'(rden1_cnt), 384'(128));
        checkOutput("pkt5_addr_range", 384'({rden1_first[15:0], rden1_last[15:0]}), 384'({16'd128, 16'd255}));
        @(negedge ram_clk);
        checkOutput("pkt5_status", 384'(pkt_valid), 384'(12'hFDF));

        // Free packet 0 so the writer restarts there, then read packet 4 concurrently
        readPacket(0, "read_pkt0");
        repeat (10) @(negedge ram_clk);
        applyStimulus(1'b1, 4'd4);
        @(negedge ram_clk);
        checkOutput("concurrent_ack", 384'({rd_ack, ram_wren}), 384'({1'b1, 3'b001}));
        sl = last_cnt;
        applyStimulus(1'b0, 4'd4);
        waitReadDone(sl, "read_pkt4_done");
        for (int i = 0; i < 300; i++) begin
            @(negedge ram_clk);
            if (done_cnt >= 13) break;
        end
        checkOutput("pkt0_rewritten", 384'(done_cnt), 384'(13));

        // Same-bank conflict: read packet 0 while packet 1 is being written
        readPacket(1, "read_pkt1");
        repeat (10) @(negedge ram_clk);
        e0 = err_pulse_cnt;
        d0 = done_cnt;
        applyStimulus(1'b1, 4'd0);
        @(negedge ram_clk);
        checkOutput("conflict_stall", 384'({rd_ack, rd_err, ram_wren}), 384'({1'b0, 1'b0, 3'b001}));
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge ram_clk);
            if (rd_ack) begin
                ok = 1;
                break;
            end
        end
        checkOutput("conflict_resolved", 384'({ok, done_cnt > d0, err_pulse_cnt == e0}), 384'(3'b111));
        sl = last_cnt;
        applyStimulus(1'b0, 4'd0);
        waitReadDone(sl, "read_pkt0b_done");

        // Random traffic with one reset in the middle
        wr_mode = 2;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                applyStimulus(1'b0, 4'd0);
                #2 rst = 1'b1;
                applyStimulus(1'b0, 4'd0);
                applyStimulus(1'b0, 4'd0);
                rst = 1'b0;
            end
            applyStimulus($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)));
        end
        wr_mode = 0;
        applyStimulus(1'b0, 4'd0);
        repeat (PKT_WORDS + 5) @(negedge ram_clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
